// File: rtl/sram_mem_responder.sv
// sram_mem_responder
// Serves 32-bit MEM-stage loads/stores from a 16-bit asynchronous SRAM as two
// halfword accesses (low halfword first). Lowers `ready` while busy so the
// pipeline can use ~ready as its global freeze.
//
// Optional feature: define SRAM_RESP_READ_HIT_EN to add a one-entry read
// buffer that lets a repeated load skip the SRAM (IDLE -> DONE in 2 clocks).
//
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   rdEn, wrEn            load / store request (store wins when both are high)
//   address, writeData    CPU byte address and store data
//   readData              load data, valid while ready=1 in DONE
//   ready                 combinational; 0 = pipeline must freeze
//   sram_addr             SRAM halfword address
//   sram_dq_out/in/oe     split SRAM data bus; oe=1 when this block drives DQ
//   sram_we_n             SRAM write strobe, active low, registered
module sram_mem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'd1024,
  parameter int unsigned SRAM_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdEn,
  input  logic        wrEn,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  localparam int unsigned IDX_W = 17;
  localparam int unsigned CNT_W = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SRAM_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_LO,
    S_W_HI,
    S_R_LO,
    S_R_HI,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx_q;      // word index latched at request acceptance
  logic [15:0]      wdata_hi_q; // upper store halfword latched at acceptance

  // Only bits [18:0] of the offset matter; the subtraction is done at that width.
  logic [18:0]      off_lo;
  logic [IDX_W-1:0] idx;
  logic             unused_bits;

  assign off_lo      = address[18:0] - BASE_ADDR[18:0];
  assign idx         = off_lo[18:2];
  assign unused_bits = ^{address[31:19], off_lo[1:0]};

  wire last_clk = (cnt == CNT_LAST);

`ifdef SRAM_RESP_READ_HIT_EN
  logic             buf_valid;
  logic [IDX_W-1:0] buf_tag;
  logic [31:0]      buf_data;
  wire              buf_match = buf_valid && (buf_tag == idx);
  wire              read_hit  = rdEn && !wrEn && buf_match;
`endif

  // Freeze request: low whenever a request is pending or in flight.
  always_comb begin
    ready = 1'b0;
    case (state)
      S_IDLE:  ready = !(rdEn || wrEn);
      S_DONE:  ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // Controller FSM with registered SRAM pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idx_q       <= '0;
      wdata_hi_q  <= '0;
      readData    <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
`ifdef SRAM_RESP_READ_HIT_EN
      buf_valid   <= 1'b0;
      buf_tag     <= '0;
      buf_data    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (wrEn) begin
            state       <= S_W_LO;
            idx_q       <= idx;
            wdata_hi_q  <= writeData[31:16];
            sram_addr   <= {idx, 1'b0};
            sram_dq_out <= writeData[15:0];
            sram_dq_oe  <= 1'b1;
            sram_we_n   <= 1'b0;
`ifdef SRAM_RESP_READ_HIT_EN
            // Keep the buffered copy coherent with the store.
            if (buf_match) buf_data <= writeData;
`endif
          end else if (rdEn) begin
`ifdef SRAM_RESP_READ_HIT_EN
            if (read_hit) begin
              state    <= S_DONE;
              readData <= buf_data;
            end else begin
              state     <= S_R_LO;
              idx_q     <= idx;
              sram_addr <= {idx, 1'b0};
            end
`else
            state     <= S_R_LO;
            idx_q     <= idx;
            sram_addr <= {idx, 1'b0};
`endif
          end
        end

        S_W_LO: begin
          if (last_clk) begin
            cnt         <= '0;
            state       <= S_W_HI;
            sram_addr   <= {idx_q, 1'b1};
            sram_dq_out <= wdata_hi_q;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_W_HI: begin
          if (last_clk) begin
            cnt        <= '0;
            state      <= S_DONE;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_R_LO: begin
          if (last_clk) begin
            cnt            <= '0;
            state          <= S_R_HI;
            readData[15:0] <= sram_dq_in;
            sram_addr      <= {idx_q, 1'b1};
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_R_HI: begin
          if (last_clk) begin
            cnt             <= '0;
            state           <= S_DONE;
            readData[31:16] <= sram_dq_in;
`ifdef SRAM_RESP_READ_HIT_EN
            buf_valid <= 1'b1;
            buf_tag   <= idx_q;
            buf_data  <= {sram_dq_in, readData[15:0]};
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_DONE: begin
          cnt   <= '0;
          state <= S_IDLE;
        end

        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_mem_responder.sv
// Directed bench for sram_mem_responder with a small behavioural SRAM model.
module tb_sram_mem_responder;

  localparam int LAT_MISS = 6;
`ifdef SRAM_RESP_READ_HIT_EN
  localparam int LAT_HIT = 2;
`else
  localparam int LAT_HIT = 6;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdEn = 1'b0;
  logic        wrEn = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] writeData = 32'd0;
  logic [31:0] readData;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_mem_responder #(.BASE_ADDR(32'd1024), .SRAM_WAIT(2)) dut (
    .clk(clk), .rst(rst), .rdEn(rdEn), .wrEn(wrEn), .address(address),
    .writeData(writeData), .readData(readData), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  // Asynchronous SRAM model: combinational read, write while we_n is low.
  logic [15:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  assign sram_dq_in = mem[sram_addr[7:0]];
  always @(posedge clk) if (!sram_we_n) mem[sram_addr[7:0]] <= sram_dq_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] exp_rdata;
    logic [17:0] exp_lo;   // first halfword address with we_n low (stores only)
  } vec_t;

  // Issue one request, wait (bounded) for ready, check latency/result, release.
  task automatic run_op(input vec_t v);
    int          cyc;
    logic        saw_we;
    logic [17:0] first_wa, last_wa;
    rdEn = v.rd; wrEn = v.wr; address = v.addr; writeData = v.wdata;
    #1;
    chk({v.name, "_ready_c0"}, 32'(ready), 32'd0);
    cyc = 0; saw_we = 1'b0; first_wa = '0; last_wa = '0;
    while (ready !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
      if (sram_we_n === 1'b0) begin
        if (!saw_we) first_wa = sram_addr;
        last_wa = sram_addr;
        saw_we = 1'b1;
      end
    end
    chk({v.name, "_latency"}, 32'(cyc + 1), 32'(v.lat));
    chk({v.name, "_rdata"}, readData, v.exp_rdata);
    chk({v.name, "_we_seen"}, 32'(saw_we), 32'(v.wr));
    if (v.wr) begin
      chk({v.name, "_lo_addr"}, 32'(first_wa), 32'(v.exp_lo));
      chk({v.name, "_hi_addr"}, 32'(last_wa), 32'(v.exp_lo + 18'd1));
    end
    step();
    rdEn = 1'b0; wrEn = 1'b0;
    #1;
  endtask

  vec_t vecs [0:9];

  initial begin
    vecs[0] = '{"ld1024",    1'b1, 1'b0, 32'd1024, 32'h0,         LAT_MISS, 32'hDEADBEEF, 18'd0};
    vecs[1] = '{"ld1024_2",  1'b1, 1'b0, 32'd1024, 32'h0,         LAT_HIT,  32'hDEADBEEF, 18'd0};
    vecs[2] = '{"st1028",    1'b0, 1'b1, 32'd1028, 32'h12345678,  LAT_MISS, 32'hDEADBEEF, 18'd2};
    vecs[3] = '{"ld1028",    1'b1, 1'b0, 32'd1028, 32'h0,         LAT_MISS, 32'h12345678, 18'd0};
    vecs[4] = '{"ld1024_3",  1'b1, 1'b0, 32'd1024, 32'h0,         LAT_MISS, 32'hDEADBEEF, 18'd0};
    vecs[5] = '{"ld1028_2",  1'b1, 1'b0, 32'd1028, 32'h0,         LAT_MISS, 32'h12345678, 18'd0};
    vecs[6] = '{"st1028_b",  1'b0, 1'b1, 32'd1028, 32'hCAFEF00D,  LAT_MISS, 32'h12345678, 18'd2};
    vecs[7] = '{"ld1028_3",  1'b1, 1'b0, 32'd1028, 32'h0,         LAT_HIT,  32'hCAFEF00D, 18'd0};
    vecs[8] = '{"ld1026",    1'b1, 1'b0, 32'd1026, 32'h0,         LAT_MISS, 32'hDEADBEEF, 18'd0};
    vecs[9] = '{"both1032",  1'b1, 1'b1, 32'd1032, 32'hA5A55A5A,  LAT_MISS, 32'hDEADBEEF, 18'd4};

    // Reset and idle state.
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_rdata", readData, 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);

    // Cycle-by-cycle store of 0xDEADBEEF to 1024.
    wrEn = 1'b1; address = 32'd1024; writeData = 32'hDEADBEEF;
    #1;
    chk("st_c0_ready", 32'(ready), 32'd0);
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c <= 4) begin
        chk("st_ready", 32'(ready), 32'd0);
        chk("st_we_n", 32'(sram_we_n), 32'd0);
        chk("st_oe", 32'(sram_dq_oe), 32'd1);
        chk("st_addr", 32'(sram_addr), (c <= 2) ? 32'd0 : 32'd1);
        chk("st_dq", 32'(sram_dq_out), (c <= 2) ? 32'h0000BEEF : 32'h0000DEAD);
      end else begin
        chk("st_done_ready", 32'(ready), 32'd1);
        chk("st_done_we_n", 32'(sram_we_n), 32'd1);
        chk("st_done_oe", 32'(sram_dq_oe), 32'd0);
      end
    end
    step();
    wrEn = 1'b0;
    #1;
    chk("st_mem_lo", 32'(mem[0]), 32'h0000BEEF);
    chk("st_mem_hi", 32'(mem[1]), 32'h0000DEAD);

    // Table of load/store transactions.
    for (int i = 0; i < 10; i++) run_op(vecs[i]);

    // The simultaneous request must have stored the data.
    run_op('{"ld1032", 1'b1, 1'b0, 32'd1032, 32'h0, LAT_MISS, 32'hA5A55A5A, 18'd0});

    // Reset during cycle 2 of a store.
    wrEn = 1'b1; address = 32'd1036; writeData = 32'h11112222;
    step();
    step();
    chk("rstmid_we_low", 32'(sram_we_n), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0; wrEn = 1'b0;
    #1;
    chk("rstmid_we_n", 32'(sram_we_n), 32'd1);
    chk("rstmid_oe", 32'(sram_dq_oe), 32'd0);
    chk("rstmid_ready", 32'(ready), 32'd1);
    chk("rstmid_rdata", readData, 32'd0);
    step();
    chk("rstmid_idle_ready", 32'(ready), 32'd1);

    // After reset the buffer (if any) is empty, so this is a full-length read.
    run_op('{"ld_after_rst", 1'b1, 1'b0, 32'd1024, 32'h0, LAT_MISS, 32'hDEADBEEF, 18'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
